// File: rtl/fx_pkg.sv
// Shared fixed-point definitions for the sign-magnitude Q1.15 arithmetic blocks.
package fx_pkg;

    localparam int N_BITS    = 16;
    localparam int FRAC_BITS = 15;

    typedef logic [15:0] q15_t;

    localparam logic [14:0] Q15_MAG_MAX = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/divider_q15.sv
// Sign-magnitude Q1.15 restoring divider, one quotient bit per clock, with
// valid/ready handshakes and saturation on overflow or divide-by-zero.
module divider_q15
    import fx_pkg::*;
#(
    parameter int N    = N_BITS,
    parameter int FRAC = N - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam int CW = $clog2(FRAC + 1);

    div_state_t      state_q, state_d;
    logic [N-1:0]    r_q, r_d;
    logic [FRAC-1:0] bmag_q, bmag_d;
    logic [FRAC-1:0] quot_q, quot_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [N-1:0]    q_q, q_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;
    logic            out_valid_q, out_valid_d;

    logic [FRAC-1:0] a_mag, b_mag;
    logic [N-1:0]    r2;
    logic            qbit;
    logic            in_sign;

    assign a_mag   = a[FRAC-1:0];
    assign b_mag   = b[FRAC-1:0];
    assign in_sign = a[N-1] ^ b[N-1];

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        bmag_d      = bmag_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        q_d         = q_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        r2          = r_q << 1;
        qbit        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b0;
                    if (b_mag == '0) begin
                        dbz_d       = 1'b1;
                        q_d         = {in_sign, {FRAC{1'b1}}};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (a_mag >= b_mag) begin
                        ovf_d       = 1'b1;
                        q_d         = {in_sign, {FRAC{1'b1}}};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        r_d     = {1'b0, a_mag};
                        bmag_d  = b_mag;
                        quot_d  = '0;
                        cnt_d   = '0;
                        q_d     = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // r < |b| < 2^(N-1), so the doubled remainder always fits in N bits.
                if (r2 >= {1'b0, bmag_q}) begin
                    qbit = 1'b1;
                    r_d  = r2 - {1'b0, bmag_q};
                end else begin
                    r_d = r2;
                end
                quot_d = {quot_q[FRAC-2:0], qbit};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(FRAC - 1)) begin
                    q_d         = {sign_q, quot_d};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            bmag_q      <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            q_q         <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            bmag_q      <= bmag_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            q_q         <= q_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign q           = q_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_q15.sv
// Scoreboard bench for divider_q15: driver pushes reference results, a monitor
// pops and compares them whenever the divider presents an output.
module tb_divider_q15;
    import fx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    q15_t a;
    q15_t b;
    logic out_valid;
    logic out_ready = 1'b1;
    q15_t q;
    logic overflow;
    logic div_by_zero;

    divider_q15 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic        ovf;
        logic        dbz;
        int          acceptCyc;
        int          lat;
    } expect_t;

    expect_t sb[$];
    expect_t monExp;
    int      vectors     = 0;
    int      miscompares = 0;
    int      cyc         = 0;
    bit      prevValid   = 1'b0;
    bit      randReady   = 1'b0;
    bit      forceReady  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = randReady ? 1'($urandom_range(0, 1)) : forceReady;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Reference: plain integer division of the magnitudes, saturating on |a|>=|b|.
    function automatic expect_t model(input logic [15:0] ta, input logic [15:0] tb_,
                                      input int acc);
        expect_t e;
        int      am;
        int      bm;
        logic    sign;
        am          = int'(ta[14:0]);
        bm          = int'(tb_[14:0]);
        sign        = ta[15] ^ tb_[15];
        e.acceptCyc = acc;
        e.dbz       = (bm == 0);
        e.ovf       = !e.dbz && (am >= bm);
        if (e.dbz || e.ovf) begin
            e.q   = {sign, Q15_MAG_MAX};
            e.lat = 1;
        end else begin
            e.q   = {sign, 15'((am * 32768) / bm)};
            e.lat = FRAC_BITS + 1;
        end
        return e;
    endfunction

    task automatic waitIdle(input string name);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got in_ready=%b, want 1 within 200 cycles", name, in_ready);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_, input bit track);
        waitIdle("accept_timeout");
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        if (track) sb.push_back(model(ta, tb_, cyc));
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, want 0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL spurious_output: got q=0x%h, want no output", q);
            end else begin
                monExp = sb[0];
                checkOutput("q", 32'(q), 32'(monExp.q));
                checkOutput("overflow", 32'(overflow), 32'(monExp.ovf));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(monExp.dbz));
                checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
                if (!prevValid)
                    checkOutput("latency", 32'(cyc - monExp.acceptCyc + 1), 32'(monExp.lat));
                if (out_ready) void'(sb.pop_front());
            end
        end
        prevValid = rst_n && out_valid;
    end

    logic [15:0] dirA [10] = '{16'h2000, 16'hA000, 16'h2000, 16'hA000, 16'h1000,
                                16'h0000, 16'h4000, 16'hC000, 16'h0123, 16'h0000};
    logic [15:0] dirB [10] = '{16'h4000, 16'h4000, 16'hC000, 16'hC000, 16'h3000,
                                16'h1234, 16'h2000, 16'h4000, 16'h8000, 16'h8000};

    initial begin
        int guard;
        int am;
        int bm;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) applyStimulus(dirA[i], dirB[i], 1'b1);
        waitDrain();

        $display("[TB] backpressure with ignored second request");
        forceReady = 1'b0;
        applyStimulus(16'h1000, 16'h3000, 1'b1);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL bp_wait: got out_valid=%b, want 1 within 100 cycles", out_valid);
        end
        @(posedge clk);
        #1;
        a        = 16'h0100;
        b        = 16'h0200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_out_valid_held", 32'(out_valid), 32'd1);
        forceReady = 1'b1;
        waitDrain();

        $display("[TB] randomized operands with random out_ready");
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            if ($urandom_range(0, 3) != 0) begin
                bm = int'($urandom_range(1, 32767));
                am = int'($urandom_range(0, 32'(bm - 1)));
                ra = {1'($urandom), 15'(am)};
                rb = {1'($urandom), 15'(bm)};
            end else begin
                ra = 16'($urandom);
                rb = 16'($urandom);
            end
            applyStimulus(ra, rb, 1'b1);
        end
        randReady  = 1'b0;
        forceReady = 1'b1;
        waitDrain();

        $display("[TB] reset during iteration");
        waitIdle("rst_accept_timeout");
        a        = 16'h2000;
        b        = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midcalc_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midcalc_q", 32'(q), 32'd0);
        checkOutput("midcalc_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(16'h2000, 16'h4000, 1'b1);
        waitDrain();
        repeat (25) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
